tdm_demux153: RTL and testbench

TDM_DEMUX153 -- requirements
Module: tdm_demux153

---
 rtl/tdm_demux153.sv | 105 ++++++++++
 tb/tb_tdm_demux153.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux153.sv
// tdm_demux153: two-lane, four-slot TDM demultiplexer.
// Locks to a frame-start marker, steps a slot index {s1,s0} for the far-end
// mux, gathers one sample per slot per lane and presents each completed frame
// as registered words with a one-cycle frame_valid pulse.
module tdm_demux153 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e_n,
  input  logic             sync,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic             s1,
  output logic             s0,
  output logic [WIDTH-1:0] ya0,
  output logic [WIDTH-1:0] ya1,
  output logic [WIDTH-1:0] ya2,
  output logic [WIDTH-1:0] ya3,
  output logic [WIDTH-1:0] yb0,
  output logic [WIDTH-1:0] yb1,
  output logic [WIDTH-1:0] yb2,
  output logic [WIDTH-1:0] yb3,
  output logic             frame_valid,
  output logic             sync_err,
  output logic [7:0]       frame_cnt
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [1:0]       slot_q;
  // Slot 3 never needs a shadow: its sample goes straight to ya3/yb3.
  logic [WIDTH-1:0] sha_q [3];
  logic [WIDTH-1:0] shb_q [3];

  // Slot select is the registered slot index, so there is no input-to-output path.
  assign s1 = slot_q[1];
  assign s0 = slot_q[0];

  // Lock/slot FSM, per-slot capture, frame load and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      slot_q      <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        sha_q[i] <= '0;
        shb_q[i] <= '0;
      end
      ya0         <= '0;
      ya1         <= '0;
      ya2         <= '0;
      ya3         <= '0;
      yb0         <= '0;
      yb1         <= '0;
      yb2         <= '0;
      yb3         <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (!e_n) begin
        unique case (state_q)
          StIdle: begin
            if (sync) begin
              sha_q[0] <= d1;
              shb_q[0] <= d2;
              slot_q   <= 2'd1;
              state_q  <= StRun;
            end
          end
          StRun: begin
            if (sync && (slot_q != 2'd0)) begin
              // Misplaced marker: drop the partial frame and restart at slot 0.
              sync_err <= 1'b1;
              sha_q[0] <= d1;
              shb_q[0] <= d2;
              slot_q   <= 2'd1;
            end else if (slot_q == 2'd3) begin
              ya0         <= sha_q[0];
              ya1         <= sha_q[1];
              ya2         <= sha_q[2];
              ya3         <= d1;
              yb0         <= shb_q[0];
              yb1         <= shb_q[1];
              yb2         <= shb_q[2];
              yb3         <= d2;
              frame_valid <= 1'b1;
              frame_cnt   <= frame_cnt + 8'd1;
              slot_q      <= 2'd0;
            end else begin
              sha_q[slot_q] <= d1;
              shb_q[slot_q] <= d2;
              slot_q        <= slot_q + 2'd1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux153.sv
module tb_tdm_demux153;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, e_n, sync;
  logic [W-1:0] d1, d2;
  logic         s1, s0, frame_valid, sync_err;
  logic [W-1:0] ya0, ya1, ya2, ya3, yb0, yb1, yb2, yb3;
  logic [7:0]   frame_cnt;

  tdm_demux153 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .e_n(e_n), .sync(sync), .d1(d1), .d2(d2),
    .s1(s1), .s0(s0),
    .ya0(ya0), .ya1(ya1), .ya2(ya2), .ya3(ya3),
    .yb0(yb0), .yb1(yb1), .yb2(yb2), .yb3(yb3),
    .frame_valid(frame_valid), .sync_err(sync_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int fv_seen = 0;

  // Behavioural model: a frame is just the list of samples gathered since lock.
  bit       m_locked;
  int       qa[$];
  int       qb[$];
  int       m_ya[4];
  int       m_yb[4];
  int       m_fv, m_err, m_cnt;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_edge(input bit r, input bit en_n, input bit sy, input int a, input int b);
    m_fv  = 0;
    m_err = 0;
    if (r) begin
      m_locked = 0;
      qa.delete();
      qb.delete();
      for (int i = 0; i < 4; i++) begin m_ya[i] = 0; m_yb[i] = 0; end
      m_cnt = 0;
    end else if (!en_n) begin
      if (!m_locked) begin
        if (sy) begin
          m_locked = 1;
          qa.push_back(a);
          qb.push_back(b);
        end
      end else begin
        if (sy && qa.size() != 0) begin
          m_err = 1;
          qa.delete();
          qb.delete();
        end
        qa.push_back(a);
        qb.push_back(b);
        if (qa.size() == 4) begin
          for (int i = 0; i < 4; i++) begin m_ya[i] = qa[i]; m_yb[i] = qb[i]; end
          m_fv  = 1;
          m_cnt = (m_cnt + 1) % 256;
          qa.delete();
          qb.delete();
        end
      end
    end
  endtask

  // Compare every DUT output with the model after each edge.
  task automatic compare_all();
    chk("slot", {30'd0, s1, s0}, qa.size());
    chk("ya0", int'(ya0), m_ya[0]);
    chk("ya1", int'(ya1), m_ya[1]);
    chk("ya2", int'(ya2), m_ya[2]);
    chk("ya3", int'(ya3), m_ya[3]);
    chk("yb0", int'(yb0), m_yb[0]);
    chk("yb1", int'(yb1), m_yb[1]);
    chk("yb2", int'(yb2), m_yb[2]);
    chk("yb3", int'(yb3), m_yb[3]);
    chk("frame_valid", int'(frame_valid), m_fv);
    chk("sync_err", int'(sync_err), m_err);
    chk("frame_cnt", int'(frame_cnt), m_cnt);
    chk("fv_err_exclusive", int'(frame_valid & sync_err), 0);
    if (frame_valid) fv_seen++;
  endtask

  task automatic step(input bit r, input bit en_n, input bit sy, input int a, input int b);
    rst  = r;
    e_n  = en_n;
    sync = sy;
    d1   = W'(a);
    d2   = W'(b);
    @(posedge clk);
    model_edge(r, en_n, sy, a, b);
    #1;
    compare_all();
  endtask

  initial begin
    m_locked = 0;
    m_cnt = 0;
    for (int i = 0; i < 4; i++) begin m_ya[i] = 0; m_yb[i] = 0; end
    rst = 1; e_n = 0; sync = 0; d1 = '0; d2 = '0;

    // Reset, with sync asserted to show reset wins.
    step(1, 0, 1, 7, 7);
    step(1, 0, 0, 0, 0);
    chk("lit_reset_cnt", int'(frame_cnt), 0);
    chk("lit_reset_slot", {30'd0, s1, s0}, 0);

    // Disabled block ignores sync while unlocked.
    step(0, 1, 1, 3, 3);
    chk("lit_idle_disabled_slot", {30'd0, s1, s0}, 0);

    // First frame: 1,2,3,4 / A,B,C,D.
    step(0, 0, 1, 1, 'hA);
    step(0, 0, 0, 2, 'hB);
    step(0, 0, 0, 3, 'hC);
    step(0, 0, 0, 4, 'hD);
    chk("lit_f1_ya0", int'(ya0), 1);
    chk("lit_f1_ya3", int'(ya3), 4);
    chk("lit_f1_yb2", int'(yb2), 'hC);
    chk("lit_f1_fv", int'(frame_valid), 1);
    chk("lit_f1_cnt", int'(frame_cnt), 1);

    // Second frame free-running, no sync.
    step(0, 0, 0, 5, 'hE);
    chk("lit_fv_one_cycle", int'(frame_valid), 0);
    step(0, 0, 0, 6, 'hF);
    step(0, 0, 0, 7, 0);
    step(0, 0, 0, 8, 1);
    chk("lit_f2_ya0", int'(ya0), 5);
    chk("lit_f2_cnt", int'(frame_cnt), 2);

    // Sync re-asserted at slot 2.
    step(0, 0, 1, 9, 9);
    step(0, 0, 0, 10, 10);
    step(0, 0, 1, 11, 12);
    chk("lit_err", int'(sync_err), 1);
    chk("lit_err_ya0_held", int'(ya0), 5);
    chk("lit_err_slot", {30'd0, s1, s0}, 1);
    step(0, 0, 0, 12, 13);
    step(0, 0, 0, 13, 14);
    step(0, 0, 0, 14, 15);
    chk("lit_f3_ya0", int'(ya0), 11);
    chk("lit_f3_yb3", int'(yb3), 15);

    // Pause at slot 1 for three cycles.
    step(0, 0, 0, 1, 2);
    step(0, 1, 1, 9, 9);
    step(0, 1, 0, 9, 9);
    step(0, 1, 0, 9, 9);
    chk("lit_pause_slot", {30'd0, s1, s0}, 1);
    step(0, 0, 0, 3, 4);
    step(0, 0, 0, 5, 6);
    step(0, 0, 0, 7, 8);
    chk("lit_f4_ya1", int'(ya1), 3);
    chk("lit_f4_cnt", int'(frame_cnt), 4);

    // Reset at slot 2, then samples without sync are ignored.
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 2, 2);
    step(1, 0, 0, 3, 3);
    chk("lit_rst_mid_ya0", int'(ya0), 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, i + 1, i + 2);
    chk("lit_rst_unlocked_slot", {30'd0, s1, s0}, 0);

    // 256 frames: counter wraps to 0.
    fv_seen = 0;
    for (int f = 0; f < 256; f++) begin
      for (int s = 0; s < 4; s++) begin
        step(0, 0, (f == 0 && s == 0), int'($urandom_range(15)), int'($urandom_range(15)));
      end
    end
    chk("lit_wrap_cnt", int'(frame_cnt), 0);
    chk("lit_wrap_pulses", fv_seen, 256);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
